floor_request_dispatcher: RTL and testbench

//  Upstream stage of the dual-car elevator core (main_). Accepts hall/cab floor

---
 rtl/elevator_pkg.sv | 14 +
 rtl/floor_request_dispatcher_fifo.sv | 42 ++++
 rtl/floor_request_dispatcher.sv | 143 ++++++++++++++
 tb/tb_floor_request_dispatcher.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Constants and FSM state type shared by the elevator core stages.
package elevator_pkg;
  localparam int FLOOR_W    = 3;
  localparam int WEIGHT_W   = 11;
  localparam int MAX_FLOOR  = 7;
  localparam int MAX_WEIGHT = 700;
  localparam int DEPTH      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2
  } disp_state_e;
endpackage

// File: rtl/floor_request_dispatcher_fifo.sv
// Synchronous FIFO holding queued {floor, weight} calls; extra pointer bit gives count.
module req_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/floor_request_dispatcher.sv
// Buffers floor calls with duplicate suppression and issues one request at a time to the car.
module floor_request_dispatcher #(
  parameter int DEPTH      = elevator_pkg::DEPTH,
  parameter int MAX_FLOOR  = elevator_pkg::MAX_FLOOR,
  parameter int MAX_WEIGHT = elevator_pkg::MAX_WEIGHT,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W,
  parameter int WEIGHT_W   = elevator_pkg::WEIGHT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   call_valid,
  input  logic [FLOOR_W-1:0]     call_floor,
  input  logic [WEIGHT_W-1:0]    call_weight,
  output logic                   call_ready,
  input  logic                   complete,
  input  logic                   over_weight,
  output logic [FLOOR_W-1:0]     req_floor,
  output logic [WEIGHT_W-1:0]    weight,
  output logic                   req_active,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   call_reject,
  output logic                   call_merged,
  output logic                   req_dropped
);
  import elevator_pkg::disp_state_e;
  import elevator_pkg::IDLE;
  import elevator_pkg::SETTLE;
  import elevator_pkg::WAIT;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = FLOOR_W + WEIGHT_W;
  localparam int NFLR  = 1 << FLOOR_W;

  disp_state_e         state_q, state_d;
  logic [FLOOR_W-1:0]  req_floor_q, req_floor_d;
  logic [WEIGHT_W-1:0] weight_q, weight_d;
  logic                req_active_q, req_active_d;
  logic [NFLR-1:0]     pending_q, pending_d;
  logic                reject_q, reject_d;
  logic                merged_q, merged_d;
  logic                dropped_q, dropped_d;

  logic                fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [ENT_W-1:0]    head;
  logic [FLOOR_W-1:0]  head_floor;
  logic [WEIGHT_W-1:0] head_weight;
  logic                accept, legal, dup, push, pop;

  assign {head_floor, head_weight} = head;

  assign call_ready = !fifo_full;
  assign accept     = call_valid && call_ready;
  assign legal      = (int'(call_floor) <= MAX_FLOOR) && (int'(call_weight) <= MAX_WEIGHT)
                      && (call_weight != '0);
  // A head popped this edge keeps its pending bit until the edge, so a same-floor
  // call merges against the newly issued request.
  assign dup        = pending_q[call_floor] || (req_active_q && (req_floor_q == call_floor));
  assign push       = accept && legal && !dup;
  assign pop        = (state_q == IDLE) && !fifo_empty;

  req_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({call_floor, call_weight}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    pending_d = pending_q;
    if (pop)  pending_d[head_floor] = 1'b0;
    if (push) pending_d[call_floor] = 1'b1;
  end

  assign reject_d = accept && !legal;
  assign merged_d = accept && legal && dup;

  always_comb begin
    state_d      = state_q;
    req_floor_d  = req_floor_q;
    weight_d     = weight_q;
    req_active_d = req_active_q;
    dropped_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          req_floor_d  = head_floor;
          weight_d     = head_weight;
          req_active_d = 1'b1;
          state_d      = SETTLE;
        end
      end
      // complete/over_weight may still be high from the previous trip here
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (over_weight) begin
          dropped_d    = 1'b1;
          req_active_d = 1'b0;
          state_d      = IDLE;
        end else if (complete) begin
          req_active_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_floor_q  <= '0;
      weight_q     <= '0;
      req_active_q <= 1'b0;
      pending_q    <= '0;
      reject_q     <= 1'b0;
      merged_q     <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_floor_q  <= req_floor_d;
      weight_q     <= weight_d;
      req_active_q <= req_active_d;
      pending_q    <= pending_d;
      reject_q     <= reject_d;
      merged_q     <= merged_d;
      dropped_q    <= dropped_d;
    end
  end

  assign req_floor   = req_floor_q;
  assign weight      = weight_q;
  assign req_active  = req_active_q;
  assign queue_count = fifo_count;
  assign call_reject = reject_q;
  assign call_merged = merged_q;
  assign req_dropped = dropped_q;
endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Bench for floor_request_dispatcher: vector table, corner sequences, random vs queue model.
module tb_floor_request_dispatcher;
  // DEPTH=4 makes a full FIFO reachable with 8 floors; FLOOR_W=4 lets floor 9 be driven.
  localparam int DEPTH      = 4;
  localparam int MAX_FLOOR  = 7;
  localparam int MAX_WEIGHT = 700;
  localparam int FLOOR_W    = 4;
  localparam int WEIGHT_W   = 11;
  localparam int CW         = $clog2(DEPTH) + 1;
  localparam int NV         = 27;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                call_valid = 1'b0;
  logic [FLOOR_W-1:0]  call_floor = '0;
  logic [WEIGHT_W-1:0] call_weight = '0;
  logic                complete = 1'b0;
  logic                over_weight = 1'b0;
  logic                call_ready, req_active, call_reject, call_merged, req_dropped;
  logic [FLOOR_W-1:0]  req_floor;
  logic [WEIGHT_W-1:0] weight;
  logic [CW-1:0]       queue_count;

  floor_request_dispatcher #(
    .DEPTH(DEPTH), .MAX_FLOOR(MAX_FLOOR), .MAX_WEIGHT(MAX_WEIGHT),
    .FLOOR_W(FLOOR_W), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .clk(clk), .rst(rst), .call_valid(call_valid), .call_floor(call_floor),
    .call_weight(call_weight), .call_ready(call_ready), .complete(complete),
    .over_weight(over_weight), .req_floor(req_floor), .weight(weight),
    .req_active(req_active), .queue_count(queue_count), .call_reject(call_reject),
    .call_merged(call_merged), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // Reference model: a plain queue of waiting calls plus the trip in service.
  typedef struct { int f; int w; } ent_t;
  ent_t mq[$];
  bit   m_svc, m_rej, m_mrg, m_drp;
  int   m_age, m_rf, m_rw;

  function automatic void model_reset();
    mq.delete();
    m_svc = 0; m_age = 0; m_rf = 0; m_rw = 0;
    m_rej = 0; m_mrg = 0; m_drp = 0;
  endfunction

  function automatic void model_step(bit v, int f, int w, bit c, bit o);
    bit   rdy, legal, dup, issue, push;
    ent_t e;
    rdy   = mq.size() < DEPTH;
    issue = !m_svc && mq.size() > 0;
    m_rej = 0; m_mrg = 0; m_drp = 0; push = 0;
    if (v && rdy) begin
      legal = (f <= MAX_FLOOR) && (w <= MAX_WEIGHT) && (w != 0);
      dup   = m_svc && (m_rf == f);
      foreach (mq[i]) if (mq[i].f == f) dup = 1;
      m_rej = !legal;
      m_mrg = legal && dup;
      push  = legal && !dup;
    end
    if (m_svc) begin
      // car status is ignored on the first edge after issue
      if (m_age >= 1 && (o || c)) begin
        m_drp = o;
        m_svc = 0;
      end
      m_age++;
    end
    if (issue) begin
      e = mq.pop_front();
      m_rf = e.f; m_rw = e.w; m_svc = 1; m_age = 0;
    end
    if (push) begin
      e.f = f; e.w = w;
      mq.push_back(e);
    end
  endfunction

  function automatic void cmp_model();
    chk("model.req_floor",   int'(req_floor),   m_rf);
    chk("model.weight",      int'(weight),      m_rw);
    chk("model.req_active",  int'(req_active),  int'(m_svc));
    chk("model.queue_count", int'(queue_count), mq.size());
    chk("model.call_ready",  int'(call_ready),  int'(mq.size() < DEPTH));
    chk("model.call_reject", int'(call_reject), int'(m_rej));
    chk("model.call_merged", int'(call_merged), int'(m_mrg));
    chk("model.req_dropped", int'(req_dropped), int'(m_drp));
  endfunction

  function automatic void chk_reset(string tag);
    chk({tag, ".req_floor"},   int'(req_floor),   0);
    chk({tag, ".weight"},      int'(weight),      0);
    chk({tag, ".req_active"},  int'(req_active),  0);
    chk({tag, ".queue_count"}, int'(queue_count), 0);
    chk({tag, ".call_ready"},  int'(call_ready),  1);
    chk({tag, ".pulses"},      int'({call_reject, call_merged, req_dropped}), 0);
  endfunction

  task automatic drive(bit v, int f, int w, bit c, bit o);
    call_valid  = v;
    call_floor  = FLOOR_W'(f);
    call_weight = WEIGHT_W'(w);
    complete    = c;
    over_weight = o;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(call_valid, int'(call_floor), int'(call_weight), complete, over_weight);
    #1 cmp_model();
  endtask

  // Asynchronous reset in mid-cycle, checked before and after the next edge.
  task automatic mid_reset(string tag);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk_reset({tag, ".async"});
    model_reset();
    @(posedge clk);
    #1 chk_reset({tag, ".edge"});
    rst = 1'b0;
  endtask

  typedef struct { int v, f, w, c, o, rf, rw, act, cnt, rej, mrg, drp; } vec_t;
  vec_t tbl [NV];

  initial begin
    int r, w;
    //          v f  w    c o   rf rw  act cnt rej mrg drp
    tbl[0]  = '{1, 4, 250, 0, 0,  0, 0,   0, 1,  0, 0, 0};
    tbl[1]  = '{1, 7, 350, 0, 0,  4, 250, 1, 1,  0, 0, 0};
    tbl[2]  = '{1, 2, 500, 0, 0,  4, 250, 1, 2,  0, 0, 0};
    tbl[3]  = '{0, 0, 0,   1, 0,  4, 250, 0, 2,  0, 0, 0};
    tbl[4]  = '{0, 0, 0,   0, 0,  7, 350, 1, 1,  0, 0, 0};
    tbl[5]  = '{0, 0, 0,   0, 0,  7, 350, 1, 1,  0, 0, 0};
    tbl[6]  = '{0, 0, 0,   1, 0,  7, 350, 0, 1,  0, 0, 0};
    tbl[7]  = '{0, 0, 0,   0, 0,  2, 500, 1, 0,  0, 0, 0};
    tbl[8]  = '{0, 0, 0,   0, 0,  2, 500, 1, 0,  0, 0, 0};
    tbl[9]  = '{0, 0, 0,   1, 0,  2, 500, 0, 0,  0, 0, 0};
    tbl[10] = '{1, 7, 1000,0, 0,  2, 500, 0, 0,  1, 0, 0};
    tbl[11] = '{1, 9, 100, 0, 0,  2, 500, 0, 0,  1, 0, 0};
    tbl[12] = '{1, 3, 0,   0, 0,  2, 500, 0, 0,  1, 0, 0};
    tbl[13] = '{1, 4, 701, 0, 0,  2, 500, 0, 0,  1, 0, 0};
    tbl[14] = '{1, 3, 700, 0, 0,  2, 500, 0, 1,  0, 0, 0};
    tbl[15] = '{1, 3, 100, 0, 0,  3, 700, 1, 0,  0, 1, 0};
    tbl[16] = '{1, 3, 200, 0, 0,  3, 700, 1, 0,  0, 1, 0};
    tbl[17] = '{1, 5, 300, 0, 0,  3, 700, 1, 1,  0, 0, 0};
    tbl[18] = '{1, 5, 400, 0, 0,  3, 700, 1, 1,  0, 1, 0};
    tbl[19] = '{0, 0, 0,   1, 0,  3, 700, 0, 1,  0, 0, 0};
    tbl[20] = '{0, 0, 0,   0, 0,  5, 300, 1, 0,  0, 0, 0};
    tbl[21] = '{1, 6, 600, 1, 0,  5, 300, 1, 1,  0, 0, 0};
    tbl[22] = '{0, 0, 0,   1, 1,  5, 300, 0, 1,  0, 0, 1};
    tbl[23] = '{0, 0, 0,   0, 0,  6, 600, 1, 0,  0, 0, 0};
    tbl[24] = '{0, 0, 0,   0, 0,  6, 600, 1, 0,  0, 0, 0};
    tbl[25] = '{0, 0, 0,   0, 1,  6, 600, 0, 0,  0, 0, 1};
    tbl[26] = '{0, 0, 0,   0, 1,  6, 600, 0, 0,  0, 0, 0};

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v != 0, tbl[i].f, tbl[i].w, tbl[i].c != 0, tbl[i].o != 0);
      cyc();
      chk($sformatf("tbl%0d.req_floor", i),   int'(req_floor),   tbl[i].rf);
      chk($sformatf("tbl%0d.weight", i),      int'(weight),      tbl[i].rw);
      chk($sformatf("tbl%0d.req_active", i),  int'(req_active),  tbl[i].act);
      chk($sformatf("tbl%0d.queue_count", i), int'(queue_count), tbl[i].cnt);
      chk($sformatf("tbl%0d.call_reject", i), int'(call_reject), tbl[i].rej);
      chk($sformatf("tbl%0d.call_merged", i), int'(call_merged), tbl[i].mrg);
      chk($sformatf("tbl%0d.req_dropped", i), int'(req_dropped), tbl[i].drp);
    end

    // Reset while waiting on floor 4 with another call queued
    drive(1, 4, 250, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);   cyc();
    drive(1, 6, 100, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("rstwait.pre_floor",  int'(req_floor),   4);
    chk("rstwait.pre_active", int'(req_active),  1);
    chk("rstwait.pre_count",  int'(queue_count), 1);
    mid_reset("rstwait");

    // Fill to full behind a busy car, hold a call, release with one pop
    drive(1, 0, 100, 0, 0); cyc();
    drive(1, 1, 100, 0, 0); cyc();
    drive(1, 2, 100, 1, 0); cyc();
    chk("full.settle_ignores_complete", int'(req_active), 1);
    drive(1, 3, 100, 0, 0); cyc();
    drive(1, 4, 100, 0, 0); cyc();
    chk("full.count",       int'(queue_count), 4);
    chk("full.ready_low",   int'(call_ready),  0);
    drive(1, 5, 100, 0, 0); cyc();
    chk("full.held_count",  int'(queue_count), 4);
    drive(1, 5, 100, 1, 0); cyc();
    chk("full.trip_done",   int'(req_active),  0);
    drive(1, 5, 100, 0, 0); cyc();
    chk("full.pop_count",   int'(queue_count), 3);
    chk("full.pop_floor",   int'(req_floor),   1);
    chk("full.ready_back",  int'(call_ready),  1);
    cyc();
    chk("full.held_taken",  int'(queue_count), 4);
    drive(0, 0, 0, 0, 0);
    mid_reset("rnd_start");

    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(7));
      case (r)
        0:       w = 0;
        1:       w = 700;
        2:       w = 701;
        default: w = int'($urandom_range(750, 1));
      endcase
      drive($urandom_range(2) != 0, int'($urandom_range(9)), w,
            $urandom_range(3) == 0, $urandom_range(9) == 0);
      cyc();
      if ($urandom_range(599) == 0) mid_reset("rnd");
    end
    drive(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
